seq_stream_arbiter: RTL and testbench

Shares one Padovan-style sequence engine (terms 0, 1, 1, 1, 2, 2, 3, 4, 5, 7, 9, 12, …; a(n) = a(n-2) + a(n-3)) between NUM_REQ requesters. Each requester asks for the first N terms. The block grants requests round-robin, restarts the engine from term 0, and streams exactly N terms over a valid/ready output tagged with the requester ID. It sits between software-visible request ports and the shared sequence datapath.

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_core.sv | 33 +++
 rtl/seq_stream_arbiter.sv | 106 ++++++++++
 tb/tb_seq_stream_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants and types for the sequence stream arbiter.
package seq_pkg;

  localparam int SEQ_W = 32;

  // Engine seeds: the stream starts 0, 1, 1, 1, 2, ...
  localparam logic [SEQ_W-1:0] SEED_T3 = 32'd0;
  localparam logic [SEQ_W-1:0] SEED_T2 = 32'd1;
  localparam logic [SEQ_W-1:0] SEED_T1 = 32'd1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/seq_core.sv
// Padovan-style sequence engine: term = t3; step gives a(n+1) = a(n-1) + a(n-2).
module seq_core
  import seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic [SEQ_W-1:0] term
);

  logic [SEQ_W-1:0] t3, t2, t1;

  // Three-term shift with wrapping add; clear wins over step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t3 <= SEED_T3;
      t2 <= SEED_T2;
      t1 <= SEED_T1;
    end else if (clear) begin
      t3 <= SEED_T3;
      t2 <= SEED_T2;
      t1 <= SEED_T1;
    end else if (step) begin
      t3 <= t2;
      t2 <= t1;
      t1 <= t3 + t2;
    end
  end

  assign term = t3;

endmodule

// File: rtl/seq_stream_arbiter.sv
// Round-robin arbiter sharing one sequence engine among NUM_REQ requesters.
// Each grant restarts the engine and streams the requested number of terms.
module seq_stream_arbiter
  import seq_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 8,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CNT_W-1:0] req_count,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEQ_W-1:0]         out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_last,
  output logic                     busy
);

  // First set bit at or above p, wrapping around.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    p);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(p) + i) % NUM_REQ;
      if (!found && v[idx[ID_W-1:0]]) begin
        pick  = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  state_e           state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  id_q;
  logic [CNT_W-1:0] remaining;

  logic [ID_W-1:0]  grant;
  logic [CNT_W-1:0] grant_cnt;
  logic             accept;
  logic             fire;
  logic [ID_W-1:0]  ptr_nxt;

  assign grant     = rr_pick(req_valid, ptr);
  assign grant_cnt = req_count[int'(grant)*CNT_W +: CNT_W];
  // Grants depend only on state and req_valid, never on out_ready.
  assign accept    = (state == IDLE) && (|req_valid) && !reset;
  assign fire      = out_valid && out_ready;
  assign ptr_nxt   = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  // One-hot accept strobe for the selected requester.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  // Grant/stream FSM; zero-count grants are consumed without leaving IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      id_q      <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            id_q      <= grant;
            ptr       <= ptr_nxt;
            remaining <= grant_cnt;
            if (grant_cnt != '0) state <= STREAM;
          end
        end
        STREAM: begin
          if (fire) begin
            remaining <= remaining - 1'b1;
            if (out_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  seq_core u_core (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .step  (fire),
    .term  (out_data)
  );

  assign busy      = (state == STREAM);
  assign out_valid = busy;
  assign out_id    = id_q;
  assign out_last  = busy && (remaining == CNT_W'(1));

endmodule

// File: tb/tb_seq_stream_arbiter.sv
// Directed bench for seq_stream_arbiter.
module tb_seq_stream_arbiter;
  import seq_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*CNT_W-1:0] req_count;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [SEQ_W-1:0]         out_data;
  logic [1:0]               out_id;
  logic                     out_last;
  logic                     busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp5  [5];
  logic [31:0] exp12 [12];
  logic [31:0] model [255];

  seq_stream_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_count (req_count),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp5  = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2};
    exp12 = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2,
              32'd3, 32'd4, 32'd5, 32'd7, 32'd9, 32'd12};
    model[0] = 32'd0; model[1] = 32'd1; model[2] = 32'd1;
    for (int n = 3; n < 255; n++) model[n] = model[n-2] + model[n-3];

    reset     = 1'b1;
    req_valid = '0;
    req_count = '0;
    out_ready = 1'b1;

    // Reset state, with a request pending to show req_ready is held low.
    req_valid = 4'b0001;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  out_data,       32'h0);
    chk("rst_out_id",    32'(out_id),    32'h0);
    chk("rst_out_last",  32'(out_last),  32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    req_valid = '0;
    tick(); tick();
    reset = 1'b0;

    // Requester 0, count 5, no backpressure.
    req_valid = 4'b0001;
    req_count[0*CNT_W +: CNT_W] = 8'd5;
    #1;
    chk("t1_grant", 32'(req_ready), 32'h1);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t1_valid", 32'(out_valid), 32'h1);
      chk("t1_data",  out_data,       exp5[k]);
      chk("t1_id",    32'(out_id),    32'h0);
      chk("t1_last",  32'(out_last),  (k == 4) ? 32'h1 : 32'h0);
      chk("t1_busy",  32'(busy),      32'h1);
      chk("t1_noready", 32'(req_ready), 32'h0);
      tick();
    end
    #1;
    chk("t1_end_valid", 32'(out_valid), 32'h0);
    chk("t1_end_busy",  32'(busy),      32'h0);

    // Reset pointer, then all four requesters with count 2, held.
    reset = 1'b1; #2; reset = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) req_count[i*CNT_W +: CNT_W] = 8'd2;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("t2_grant", 32'(req_ready), 32'(1 << (g % 4)));
      chk("t2_gap_valid", 32'(out_valid), 32'h0);
      tick();
      for (int k = 0; k < 2; k++) begin
        #1;
        chk("t2_data", out_data,      exp5[k]);
        chk("t2_id",   32'(out_id),   32'(g % 4));
        chk("t2_last", 32'(out_last), (k == 1) ? 32'h1 : 32'h0);
        tick();
      end
    end
    req_valid = '0;
    #1;
    chk("t2_drop", 32'(req_ready), 32'h0);

    // Requester 1 (pointer now 1), count 12, out_ready toggling 1,0.
    req_valid = 4'b0010;
    req_count[1*CNT_W +: CNT_W] = 8'd12;
    #1;
    chk("t3_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    begin
      int k = 0;
      int c = 0;
      while (k < 12 && c < 60) begin
        out_ready = (c % 2 == 0);
        #1;
        chk("t3_valid", 32'(out_valid), 32'h1);
        chk("t3_data",  out_data,       exp12[k]);
        chk("t3_id",    32'(out_id),    32'h1);
        chk("t3_last",  32'(out_last),  (k == 11) ? 32'h1 : 32'h0);
        if (out_ready) k++;
        c++;
        tick();
      end
      chk("t3_done", 32'(k), 32'd12);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_end_valid", 32'(out_valid), 32'h0);

    // Requester 2 count 0 consumed with no beat, then requester 3 count 1.
    req_valid = 4'b1100;
    req_count[2*CNT_W +: CNT_W] = 8'd0;
    req_count[3*CNT_W +: CNT_W] = 8'd1;
    #1;
    chk("t4_grant2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("t4_nobeat", 32'(out_valid), 32'h0);
    chk("t4_busy0",  32'(busy),      32'h0);
    chk("t4_grant3", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    #1;
    chk("t4_valid", 32'(out_valid), 32'h1);
    chk("t4_data",  out_data,       32'h0);
    chk("t4_id",    32'(out_id),    32'h3);
    chk("t4_last",  32'(out_last),  32'h1);
    tick();
    #1;
    chk("t4_end", 32'(out_valid), 32'h0);

    // Requester 0, count 255, checked against the wrapping model.
    req_valid = 4'b0001;
    req_count[0*CNT_W +: CNT_W] = 8'd255;
    #1;
    chk("t5_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    for (int k = 0; k < 255; k++) begin
      #1;
      chk("t5_data", out_data, model[k]);
      if (k == 254) chk("t5_last", 32'(out_last), 32'h1);
      tick();
    end
    #1;
    chk("t5_end", 32'(out_valid), 32'h0);

    // Requester 2 count 10 (pointer at 1); reset on the 3rd beat.
    req_valid = 4'b0100;
    req_count[2*CNT_W +: CNT_W] = 8'd10;
    #1;
    chk("t6_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t6_data", out_data, exp5[k]);
      tick();
    end
    req_valid = 4'b0101;
    req_count[0*CNT_W +: CNT_W] = 8'd3;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'h0);
    chk("t6_rst_busy",  32'(busy),      32'h0);
    chk("t6_rst_ready", 32'(req_ready), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_regrant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t6_data2", out_data,     exp5[k]);
      chk("t6_id2",   32'(out_id),  32'h0);
      chk("t6_last2", 32'(out_last), (k == 2) ? 32'h1 : 32'h0);
      tick();
    end
    #1;
    chk("t6_end", 32'(out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
